// File: rtl/commit_tracer.sv
// commit_tracer: captures every CPU commit record into a trace FIFO, throttles the CPU through
// o_global_en so the FIFO never overflows, and drains the FIFO after a halt commit.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_commit*             commit strobe and commit record (PC, inst, halt, reg wb, dmem write)
//   o_global_en           CPU execute enable
//   o_trace_valid/i_trace_ready, o_trace_*   head-of-FIFO record with valid/ready handshake
//   o_instret             accepted commit count
//   o_halted              halt committed and FIFO drained
//   o_overflow            sticky: an accepted commit was dropped on a full FIFO
module commit_tracer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_commit,
  input  logic [31:0] i_commit_pc,
  input  logic [31:0] i_commit_inst,
  input  logic        i_commit_halt,
  input  logic        i_commit_reg_we,
  input  logic [4:0]  i_commit_reg_wa,
  input  logic [31:0] i_commit_reg_wd,
  input  logic        i_commit_dmem_we,
  input  logic [31:0] i_commit_dmem_wa,
  input  logic [31:0] i_commit_dmem_wd,
  output logic        o_global_en,
  output logic        o_trace_valid,
  input  logic        i_trace_ready,
  output logic [31:0] o_trace_pc,
  output logic [31:0] o_trace_inst,
  output logic        o_trace_halt,
  output logic        o_trace_reg_we,
  output logic [4:0]  o_trace_reg_wa,
  output logic [31:0] o_trace_reg_wd,
  output logic        o_trace_dmem_we,
  output logic [31:0] o_trace_dmem_wa,
  output logic [31:0] o_trace_dmem_wd,
  output logic [31:0] o_instret,
  output logic        o_halted,
  output logic        o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 32 + 32 + 1 + 1 + 5 + 32 + 1 + 32 + 32;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  // Stop one short of full: a commit already in flight when o_global_en falls still fits.
  localparam logic [AW:0] THRESH   = (AW + 1)'(DEPTH - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic          r_en_d;
  logic [31:0]   r_instret;
  logic          r_overflow;

  logic          w_accept, w_full, w_push, w_pop, w_halt_acc;
  logic [AW:0]   w_count_next;
  logic [1:0]    w_state_next;
  logic          w_global_en;
  logic [EW-1:0] w_wr_entry;

  // r_en_d gates the strobe so a commit held high during a stall is taken only once.
  assign w_accept   = i_commit && r_en_d;
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = o_trace_valid && i_trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_halt_acc = w_accept && i_commit_halt;

  assign w_wr_entry = {i_commit_pc, i_commit_inst, i_commit_halt, i_commit_reg_we,
                       i_commit_reg_wa, i_commit_reg_wd, i_commit_dmem_we,
                       i_commit_dmem_wa, i_commit_dmem_wd};

  assign {o_trace_pc, o_trace_inst, o_trace_halt, o_trace_reg_we, o_trace_reg_wa,
          o_trace_reg_wd, o_trace_dmem_we, o_trace_dmem_wa, o_trace_dmem_wd} = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW + 1)'(1);
    end
  end

  always_comb begin
    w_global_en  = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        // Drop enable in the halt cycle itself so the held halt strobe is never re-taken.
        w_global_en = (r_count < THRESH) && !w_halt_acc;
        if (w_halt_acc) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_count_next == '0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= ST_RUN;
      r_en_d     <= 1'b0;
      r_instret  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_en_d  <= w_global_en;
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept) r_instret <= r_instret + 32'd1;
      if (w_accept && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  assign o_global_en   = w_global_en;
  assign o_trace_valid = (r_count != '0);
  assign o_instret     = r_instret;
  assign o_halted      = (r_state == ST_DONE);
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_commit_tracer.sv
// tb_commit_tracer: directed self-checking bench for commit_tracer (DEPTH = 8).
module tb_commit_tracer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit, commit_halt, reg_we, dmem_we, ready;
  logic [31:0] commit_pc, commit_inst, reg_wd, dmem_wa, dmem_wd;
  logic [4:0]  reg_wa;
  logic        global_en, tvalid, thalt, treg_we, tdmem_we, halted, overflow;
  logic [31:0] tpc, tinst, treg_wd, tdmem_wa, tdmem_wd, instret;
  logic [4:0]  treg_wa;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_tracer #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_commit(commit), .i_commit_pc(commit_pc),
    .i_commit_inst(commit_inst), .i_commit_halt(commit_halt), .i_commit_reg_we(reg_we),
    .i_commit_reg_wa(reg_wa), .i_commit_reg_wd(reg_wd), .i_commit_dmem_we(dmem_we),
    .i_commit_dmem_wa(dmem_wa), .i_commit_dmem_wd(dmem_wd), .o_global_en(global_en),
    .o_trace_valid(tvalid), .i_trace_ready(ready), .o_trace_pc(tpc), .o_trace_inst(tinst),
    .o_trace_halt(thalt), .o_trace_reg_we(treg_we), .o_trace_reg_wa(treg_wa),
    .o_trace_reg_wd(treg_wd), .o_trace_dmem_we(tdmem_we), .o_trace_dmem_wa(tdmem_wa),
    .o_trace_dmem_wd(tdmem_wd), .o_instret(instret), .o_halted(halted),
    .o_overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Commit record fields are derived from the PC so head fields can be predicted.
  task automatic set_commit(input logic c, input logic [31:0] pc, input logic h);
    commit      = c;
    commit_pc   = pc;
    commit_inst = h ? 32'h8000_0000 : {pc[24:0], 7'h13};
    commit_halt = h;
    reg_we      = 1'b1;
    reg_wa      = pc[6:2];
    reg_wd      = ~pc;
    dmem_we     = pc[2];
    dmem_wa     = pc + 32'h1000;
    dmem_wd     = pc ^ 32'hA5A5_5A5A;
  endtask

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    set_commit(1'b0, 32'h0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_valid",    32'(tvalid),      32'd0);
    chk("rst_instret",  instret,          32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_halted",   32'(halted),      32'd0);
    chk("rst_ge",       32'(global_en),   32'd1);
    chk("rst_count",    32'(dut.r_count), 32'd0);

    // In-order pass-through with consumer always ready.
    ready = 1'b1;
    set_commit(1'b1, 32'h0, 1'b0); #1;
    chk("t1_empty_valid", 32'(tvalid), 32'd0);
    cyc();
    set_commit(1'b1, 32'h4, 1'b0); #1;
    chk("t1_valid0", 32'(tvalid), 32'd1);
    chk("t1_pc0",    tpc,         32'h0);
    chk("t1_wd0",    treg_wd,     32'hFFFF_FFFF);
    chk("t1_ge0",    32'(global_en), 32'd1);
    cyc();
    set_commit(1'b1, 32'h8, 1'b0); #1;
    chk("t1_pc4",    tpc,         32'h4);
    chk("t1_dwa4",   tdmem_wa,    32'h1004);
    cyc();
    set_commit(1'b0, 32'h8, 1'b0); #1;
    chk("t1_pc8",    tpc,         32'h8);
    chk("t1_valid8", 32'(tvalid), 32'd1);
    cyc();
    chk("t1_drained", 32'(tvalid),    32'd0);
    chk("t1_instret", instret,        32'd3);
    chk("t1_ge",      32'(global_en), 32'd1);

    // Fill with consumer stalled: enable drops at count 7, one in-flight commit lands.
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_commit(1'b1, 32'h100 + 32'(4 * i), 1'b0); #1;
      chk("t2_ge", 32'(global_en), 32'(i < 7));
      cyc();
    end
    cyc(); cyc(); cyc();
    chk("t2_count",    32'(dut.r_count), 32'd8);
    chk("t2_overflow", 32'(overflow),    32'd0);
    chk("t2_instret",  instret,          32'd11);
    chk("t2_ge",       32'(global_en),   32'd0);
    chk("t2_head",     tpc,              32'h100);

    // Non-compliant commit at full: dropped, sticky overflow, instret still counts.
    set_commit(1'b1, 32'h120, 1'b0);
    force dut.r_en_d = 1'b1;
    cyc();
    set_commit(1'b0, 32'h120, 1'b0);
    release dut.r_en_d;
    #1;
    chk("t4_overflow", 32'(overflow),    32'd1);
    chk("t4_instret",  instret,          32'd12);
    chk("t4_count",    32'(dut.r_count), 32'd8);
    chk("t4_head",     tpc,              32'h100);
    cyc();
    chk("t4_sticky",   32'(overflow),    32'd1);
    chk("t4_instret2", instret,          32'd12);

    // Pop from full; enable returns once below the threshold, then refill to 8.
    ready = 1'b1; #1;
    chk("t3_pop_pc", tpc, 32'h100);
    cyc();
    ready = 1'b0; #1;
    chk("t3_count7", 32'(dut.r_count), 32'd7);
    chk("t3_ge7",    32'(global_en),   32'd0);
    chk("t3_head",   tpc,              32'h104);
    ready = 1'b1;
    cyc();
    ready = 1'b0; #1;
    chk("t3_count6", 32'(dut.r_count), 32'd6);
    chk("t3_ge6",    32'(global_en),   32'd1);
    cyc();
    set_commit(1'b1, 32'h124, 1'b0); #1;
    chk("t3_ge6b", 32'(global_en), 32'd1);
    cyc();
    set_commit(1'b1, 32'h128, 1'b0); #1;
    chk("t3_ge7b", 32'(global_en), 32'd0);
    cyc();
    chk("t3_count8",  32'(dut.r_count), 32'd8);
    chk("t3_instret", instret,          32'd14);
    chk("t3_head2",   tpc,              32'h108);

    // Reset clears everything including overflow.
    rst = 1'b1;
    set_commit(1'b0, 32'h0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("r2_overflow", 32'(overflow),    32'd0);
    chk("r2_valid",    32'(tvalid),      32'd0);
    chk("r2_instret",  instret,          32'd0);
    chk("r2_count",    32'(dut.r_count), 32'd0);

    // Halt with three entries queued, consumer ready.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_commit(1'b1, 32'h200 + 32'(4 * i), 1'b0);
      cyc();
    end
    set_commit(1'b1, 32'h20C, 1'b1);
    ready = 1'b1; #1;
    chk("t5_ge_halt", 32'(global_en),   32'd0);
    chk("t5_pc0",     tpc,              32'h200);
    chk("t5_count",   32'(dut.r_count), 32'd3);
    cyc();
    chk("t5_pc1",     tpc,              32'h204);
    chk("t5_ge1",     32'(global_en),   32'd0);
    cyc();
    chk("t5_pc2",     tpc,              32'h208);
    cyc();
    chk("t5_pc3",     tpc,              32'h20C);
    chk("t5_thalt",   32'(thalt),       32'd1);
    chk("t5_tinst",   tinst,            32'h8000_0000);
    chk("t5_halted0", 32'(halted),      32'd0);
    cyc();
    chk("t5_halted",  32'(halted),      32'd1);
    chk("t5_valid",   32'(tvalid),      32'd0);
    chk("t5_ge",      32'(global_en),   32'd0);
    chk("t5_instret", instret,          32'd4);
    cyc();
    chk("t5_stay",    32'(halted),      32'd1);
    chk("t5_nopush",  32'(tvalid),      32'd0);

    // Reset mid-drain with two entries and a pop being offered.
    set_commit(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ready = 1'b0;
    cyc();
    set_commit(1'b1, 32'h300, 1'b0);
    cyc();
    set_commit(1'b1, 32'h304, 1'b1); #1;
    chk("t6_ge_halt", 32'(global_en), 32'd0);
    cyc();
    set_commit(1'b0, 32'h304, 1'b0); #1;
    chk("t6_count",  32'(dut.r_count), 32'd2);
    chk("t6_ge",     32'(global_en),   32'd0);
    chk("t6_halted", 32'(halted),      32'd0);
    ready = 1'b1;
    rst   = 1'b1;
    cyc();
    rst   = 1'b0;
    ready = 1'b0; #1;
    chk("t6_valid",    32'(tvalid),      32'd0);
    chk("t6_count0",   32'(dut.r_count), 32'd0);
    chk("t6_instret",  instret,          32'd0);
    chk("t6_halted0",  32'(halted),      32'd0);
    chk("t6_overflow", 32'(overflow),    32'd0);
    chk("t6_ge_run",   32'(global_en),   32'd1);
    cyc();
    chk("t6_not_done", 32'(halted),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
